dmux_1x2: RTL and testbench
===========================

# dmux_1x2

Registered 1-to-2 demultiplexer with valid/ready flow control. It routes each input word `D` to output channel 0 (`Y0`) or channel 1 (`Y1`) as chosen by `Sel`. The unselected channel is held at zero. It sits between a single producer and two independent consumers. Each channel has a one-entry output register and a saturating per-channel transfer counter.

## Interface
- `WIDTH`, default 1: data width of `D`, `Y0`, `Y1`.
- `CNT_W`, default 8: width of each transfer counter.

- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `D`  in  WIDTH  input data word.
- `Sel`  in  1  destination select: 0 → channel 0, 1 → channel 1.
- `in_valid`  in  1  producer offers `D`/`Sel` this cycle.
- `in_ready`  out  1  block accepts the offered word this cycle (combinational).
- `Y0`  out  WIDTH  channel 0 data (registered).
- `y0_valid`  out  1  channel 0 holds a word.
- `y0_ready`  in  1  consumer 0 takes the word this cycle.
- `Y1`  out  WIDTH  channel 1 data (registered).
- `y1_valid`  out  1  channel 1 holds a word.
- `y1_ready`  in  1  consumer 1 takes the word this cycle.
- `count0`  out  CNT_W  words accepted for channel 0 since reset (saturating).
- `count1`  out  CNT_W  words accepted for channel 1 since reset (saturating).

## Operation
- Reset (`rst_n`=0, asynchronous): `Y0`=0, `Y1`=0, `y0_valid`=0, `y1_valid`=0, `count0`=0, `count1`=0. These values take effect immediately and hold while reset is asserted.
- Channel k is free when `yk_valid`=0 or `yk_ready`=1.
- `in_ready` = (`Sel`=0 ? channel 0 free : channel 1 free). It depends only on `Sel`, valid and ready; it never depends on `D` or `in_valid`.
- Accept = `in_valid` && `in_ready`. On accept with `Sel`=k:
  - `Yk` ← `D`, `yk_valid` ← 1.
  - `countk` increments, unless it is all-ones, in which case it holds.
- The non-selected channel is never written by an accept. Its data and valid evolve only through its own drain.
- Drain of channel k: `yk_valid`=1 and `yk_ready`=1. If channel k is not refilled in the same cycle: `yk_valid` ← 0 and `Yk` ← 0.
- Same-cycle drain and refill of one channel: the new word loads, `yk_valid` stays 1, and the channel runs at full throughput.
- Both channels may drain in the same cycle, and both ready inputs are honoured.
- Invariant: when `yk_valid`=0, `Yk`=0. The unselected or idle output is always driven to zero, matching the combinational 1x2 demux truth table.
- `D` = 0 is a legal word. It produces `yk_valid`=1 with `Yk`=0.
- `Sel` is sampled only on accept. Changing `Sel` while not accepting has no effect on the outputs.
- Ready inputs are ignored while the corresponding valid is 0.

## Timing
- Latency: a word accepted at rising edge N appears on `Yk` with `yk_valid`=1 immediately after edge N, so it is visible in cycle N+1.
- Throughput: one word per cycle per channel when the consumer holds ready high.
- Backpressure: if channel k is full and `yk_ready`=0, then `in_ready`=0 whenever `Sel`=k.
  - Words for the other channel are still accepted if that channel is free.
- Reset mid-operation:
  - Held words are discarded and counters clear.
  - After `rst_n` rises, the first accept may occur on the first rising edge at which `rst_n`=1.
- Counters update on the same edge as the accept and are visible the next cycle.

## Test plan
- With `y0_ready`=`y1_ready`=1 and `in_valid`=1, apply four words, one cycle each, checking one cycle after each word:
  - `D`=1,`Sel`=0 → `Y0`=1, `Y1`=0, `y0_valid`=1, `y1_valid`=0.
  - `D`=1,`Sel`=1 → `Y0`=0, `Y1`=1, `y0_valid`=0, `y1_valid`=1.
  - `D`=0,`Sel`=0 → `Y0`=0, `Y1`=0, `y0_valid`=1.
  - `D`=0,`Sel`=1 → `Y0`=0, `Y1`=0, `y1_valid`=1.
  - Afterwards `count0`=2, `count1`=2.
- Backpressure:
  - Set `y0_ready`=0 and send `D`=1,`Sel`=0 → `y0_valid`=1.
  - Send a second `Sel`=0 word → `in_ready`=0 and `Y0` holds 1.
  - Switch to `Sel`=1 → `in_ready`=1 and channel 1 loads.
- Drain and refill: hold channel 0 full with `y0_ready`=1 and `in_valid`=1, `Sel`=0 for 5 cycles → `y0_valid` stays 1, `Y0` follows `D` with one cycle of delay, and `count0` increases by 5.
- Drain without refill: `y1_valid`=1, `y1_ready`=1, `in_valid`=0 → next cycle `y1_valid`=0 and `Y1`=0.
- Saturation: with `CNT_W`=2, send 6 words to channel 1 → `count1`=3 and holds at 3.
- Asynchronous reset: assert `rst_n`=0 mid-clock while both channels are valid → all outputs go to 0 before the next edge. Release reset, send `D`=1,`Sel`=0 → `Y0`=1 one cycle later.

Source files
------------

// File: rtl/dmux_1x2.sv
// Registered 1-to-2 demultiplexer with valid/ready flow control.
// Each channel owns a one-entry output register and a saturating transfer counter.
module dmux_1x2 #(
   parameter int WIDTH = 1,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] D,
   input  logic             Sel,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] Y0,
   output logic             y0_valid,
   input  logic             y0_ready,
   output logic [WIDTH-1:0] Y1,
   output logic             y1_valid,
   input  logic             y1_ready,
   output logic [CNT_W-1:0] count0,
   output logic [CNT_W-1:0] count1
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [WIDTH-1:0] r_y0;
   logic [WIDTH-1:0] r_y1;
   logic             r_v0;
   logic             r_v1;
   logic [CNT_W-1:0] r_cnt0;
   logic [CNT_W-1:0] r_cnt1;

   logic w_free0;
   logic w_free1;
   logic w_accept;
   logic w_load0;
   logic w_load1;
   logic w_drain0;
   logic w_drain1;

   // Handshake: a word moves on any edge where valid and ready are both high.
   // A channel is free when empty or being drained this cycle; in_ready is the
   // free flag of the channel Sel points at and never looks at D or in_valid.
   assign w_free0  = !r_v0 || y0_ready;
   assign w_free1  = !r_v1 || y1_ready;
   assign in_ready = Sel ? w_free1 : w_free0;
   assign w_accept = in_valid && in_ready;
   assign w_load0  = w_accept && !Sel;
   assign w_load1  = w_accept &&  Sel;
   assign w_drain0 = r_v0 && y0_ready;
   assign w_drain1 = r_v1 && y1_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_y0 <= '0;
         r_v0 <= 1'b0;
      end else if (w_load0) begin
         r_y0 <= D;
         r_v0 <= 1'b1;
      end else if (w_drain0) begin
         r_y0 <= '0;
         r_v0 <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_y1 <= '0;
         r_v1 <= 1'b0;
      end else if (w_load1) begin
         r_y1 <= D;
         r_v1 <= 1'b1;
      end else if (w_drain1) begin
         r_y1 <= '0;
         r_v1 <= 1'b0;
      end
   end

   // Counters stick at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt0 <= '0;
         r_cnt1 <= '0;
      end else begin
         if (w_load0 && (r_cnt0 != '1)) r_cnt0 <= r_cnt0 + CNT_ONE;
         if (w_load1 && (r_cnt1 != '1)) r_cnt1 <= r_cnt1 + CNT_ONE;
      end
   end

   assign Y0       = r_y0;
   assign Y1       = r_y1;
   assign y0_valid = r_v0;
   assign y1_valid = r_v1;
   assign count0   = r_cnt0;
   assign count1   = r_cnt1;

endmodule

// File: tb/tb_dmux_1x2.sv
// Bench for dmux_1x2: directed vector table, hand sequences and random traffic
// against a queue-based reference, on an 8-bit-counter and a 2-bit-counter instance.
module tb_dmux_1x2;

   logic       clk;
   logic       rst_n;
   logic [7:0] d;
   logic       sel;
   logic       in_valid;
   logic       y0_ready;
   logic       y1_ready;

   logic       in_ready_b, in_ready_s;
   logic [7:0] y0_b, y1_b, y0_s, y1_s;
   logic       v0_b, v1_b, v0_s, v1_s;
   logic [7:0] c0_b, c1_b;
   logic [1:0] c0_s, c1_s;

   int n_checks = 0;
   int n_errors = 0;

   // Reference: each channel is a queue of at most one word; counts are plain integers.
   logic [7:0] m_q0[$];
   logic [7:0] m_q1[$];
   int m_cnt0 = 0;
   int m_cnt1 = 0;

   dmux_1x2 #(.WIDTH(8), .CNT_W(8)) dut_b (
      .clk(clk), .rst_n(rst_n), .D(d), .Sel(sel), .in_valid(in_valid),
      .in_ready(in_ready_b), .Y0(y0_b), .y0_valid(v0_b), .y0_ready(y0_ready),
      .Y1(y1_b), .y1_valid(v1_b), .y1_ready(y1_ready),
      .count0(c0_b), .count1(c1_b)
   );

   dmux_1x2 #(.WIDTH(8), .CNT_W(2)) dut_s (
      .clk(clk), .rst_n(rst_n), .D(d), .Sel(sel), .in_valid(in_valid),
      .in_ready(in_ready_s), .Y0(y0_s), .y0_valid(v0_s), .y0_ready(y0_ready),
      .Y1(y1_s), .y1_valid(v1_s), .y1_ready(y1_ready),
      .count0(c0_s), .count1(c1_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] d;
      logic       sel;
      logic       v;
      logic       r0;
      logic       r1;
      logic       e_rdy;
      logic [7:0] e_y0;
      logic       e_v0;
      logic [7:0] e_y1;
      logic       e_v1;
   } vec_t;

   vec_t tbl[12];

   function automatic vec_t mk(input logic [7:0] dd, input logic s, input logic v,
                               input logic r0, input logic r1, input logic rdy,
                               input logic [7:0] ey0, input logic ev0,
                               input logic [7:0] ey1, input logic ev1);
      vec_t t;
      t.d = dd; t.sel = s; t.v = v; t.r0 = r0; t.r1 = r1; t.e_rdy = rdy;
      t.e_y0 = ey0; t.e_v0 = ev0; t.e_y1 = ey1; t.e_v1 = ev1;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int sat(input int c, input int maxv);
      return (c > maxv) ? maxv : c;
   endfunction

   function automatic logic model_ready(input logic s, input logic r0, input logic r1);
      if (s) return (m_q1.size() == 0) || r1;
      return (m_q0.size() == 0) || r0;
   endfunction

   task automatic model_reset();
      m_q0.delete();
      m_q1.delete();
      m_cnt0 = 0;
      m_cnt1 = 0;
   endtask

   task automatic compare_model(input string tag);
      logic [7:0] e0, e1;
      e0 = (m_q0.size() != 0) ? m_q0[0] : 8'd0;
      e1 = (m_q1.size() != 0) ? m_q1[0] : 8'd0;
      chk({tag, ":y0"}, 32'(y0_b), 32'(e0));
      chk({tag, ":v0"}, 32'(v0_b), 32'(m_q0.size() != 0));
      chk({tag, ":y1"}, 32'(y1_b), 32'(e1));
      chk({tag, ":v1"}, 32'(v1_b), 32'(m_q1.size() != 0));
      chk({tag, ":count0"}, 32'(c0_b), 32'(sat(m_cnt0, 255)));
      chk({tag, ":count1"}, 32'(c1_b), 32'(sat(m_cnt1, 255)));
      chk({tag, ":y0_s"}, 32'(y0_s), 32'(e0));
      chk({tag, ":y1_s"}, 32'(y1_s), 32'(e1));
      chk({tag, ":count0_s"}, 32'(c0_s), 32'(sat(m_cnt0, 3)));
      chk({tag, ":count1_s"}, 32'(c1_s), 32'(sat(m_cnt1, 3)));
   endtask

   // Called at a falling edge: drive, check in_ready, clock once, check outputs.
   task automatic step(input string tag, input logic [7:0] dd, input logic s,
                       input logic v, input logic r0, input logic r1,
                       output logic rdy_seen);
      logic mr;
      logic acc;
      d = dd; sel = s; in_valid = v; y0_ready = r0; y1_ready = r1;
      #1;
      mr = model_ready(s, r0, r1);
      rdy_seen = in_ready_b;
      chk({tag, ":in_ready"}, 32'(in_ready_b), 32'(mr));
      chk({tag, ":in_ready_s"}, 32'(in_ready_s), 32'(mr));
      acc = v && mr;
      @(posedge clk);
      if (m_q0.size() != 0 && r0) void'(m_q0.pop_front());
      if (m_q1.size() != 0 && r1) void'(m_q1.pop_front());
      if (acc && !s) begin m_q0.push_back(dd); m_cnt0++; end
      if (acc &&  s) begin m_q1.push_back(dd); m_cnt1++; end
      @(negedge clk);
      compare_model(tag);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, ":y0"}, 32'(y0_b), 32'd0);
      chk({tag, ":y1"}, 32'(y1_b), 32'd0);
      chk({tag, ":v0"}, 32'(v0_b), 32'd0);
      chk({tag, ":v1"}, 32'(v1_b), 32'd0);
      chk({tag, ":count0"}, 32'(c0_b), 32'd0);
      chk({tag, ":count1"}, 32'(c1_b), 32'd0);
      chk({tag, ":v0_s"}, 32'(v0_s), 32'd0);
      chk({tag, ":count1_s"}, 32'(c1_s), 32'd0);
   endtask

   initial begin
      logic rdy;
      int base0, base1;

      rst_n = 1'b0; d = '0; sel = 1'b0; in_valid = 1'b0; y0_ready = 1'b0; y1_ready = 1'b0;
      #1;
      check_all_zero("reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      //       d     sel   v     r0    r1    rdy   y0     v0    y1     v1
      tbl[0]  = mk(8'd1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd1, 1'b1, 8'd0, 1'b0);
      tbl[1]  = mk(8'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0, 1'b0, 8'd1, 1'b1);
      tbl[2]  = mk(8'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0, 1'b1, 8'd0, 1'b0);
      tbl[3]  = mk(8'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0, 1'b0, 8'd0, 1'b1);
      tbl[4]  = mk(8'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd1, 1'b1, 8'd0, 1'b0);
      tbl[5]  = mk(8'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1, 1'b1, 8'd0, 1'b0);
      tbl[6]  = mk(8'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1, 1'b1, 8'd3, 1'b1);
      tbl[7]  = mk(8'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1, 8'd3, 1'b1);
      tbl[8]  = mk(8'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1, 8'd3, 1'b1);
      tbl[9]  = mk(8'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1, 1'b1, 8'd0, 1'b0);
      tbl[10] = mk(8'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1, 1'b1, 8'd7, 1'b1);
      tbl[11] = mk(8'd8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd0, 1'b0, 8'd0, 1'b0);

      for (int i = 0; i < 12; i++) begin
         step($sformatf("vec%0d", i), tbl[i].d, tbl[i].sel, tbl[i].v, tbl[i].r0, tbl[i].r1, rdy);
         chk($sformatf("vec%0d:tbl_rdy", i), 32'(rdy), 32'(tbl[i].e_rdy));
         chk($sformatf("vec%0d:tbl_y0", i), 32'(y0_b), 32'(tbl[i].e_y0));
         chk($sformatf("vec%0d:tbl_v0", i), 32'(v0_b), 32'(tbl[i].e_v0));
         chk($sformatf("vec%0d:tbl_y1", i), 32'(y1_b), 32'(tbl[i].e_y1));
         chk($sformatf("vec%0d:tbl_v1", i), 32'(v1_b), 32'(tbl[i].e_v1));
         if (i == 3) begin
            chk("four_words:count0", 32'(c0_b), 32'd2);
            chk("four_words:count1", 32'(c1_b), 32'd2);
         end
      end
      chk("table:count0", 32'(c0_b), 32'd3);
      chk("table:count1", 32'(c1_b), 32'd4);
      chk("table:count1_s", 32'(c1_s), 32'd3);

      // Drain and refill channel 0 at full rate for five cycles.
      base0 = int'(c0_b);
      for (int i = 0; i < 5; i++) begin
         step("refill", 8'(8'h10 + i), 1'b0, 1'b1, 1'b1, 1'b1, rdy);
         chk("refill:rdy", 32'(rdy), 32'd1);
         chk("refill:y0", 32'(y0_b), 32'(8'h10 + i));
         chk("refill:v0", 32'(v0_b), 32'd1);
      end
      chk("refill:count0_delta", 32'(int'(c0_b) - base0), 32'd5);

      // Channel 1 saturation on the 2-bit instance.
      base1 = int'(c1_b);
      for (int i = 0; i < 7; i++) begin
         step("sat", 8'(8'h40 + i), 1'b1, 1'b1, 1'b1, 1'b1, rdy);
         chk("sat:count1_s", 32'(c1_s), 32'd3);
      end
      chk("sat:count1_delta", 32'(int'(c1_b) - base1), 32'd7);

      // Fill both channels, then drop reset in the middle of the high phase.
      step("prerst0", 8'h11, 1'b0, 1'b1, 1'b0, 1'b0, rdy);
      step("prerst1", 8'h22, 1'b1, 1'b1, 1'b0, 1'b0, rdy);
      chk("prerst:v0", 32'(v0_b), 32'd1);
      chk("prerst:v1", 32'(v1_b), 32'd1);
      in_valid = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("async_rst");
      model_reset();
      @(negedge clk);
      check_all_zero("rst_hold");
      rst_n = 1'b1;
      step("post_rst", 8'd1, 1'b0, 1'b1, 1'b1, 1'b1, rdy);
      chk("post_rst:y0", 32'(y0_b), 32'd1);
      chk("post_rst:v0", 32'(v0_b), 32'd1);
      chk("post_rst:count0", 32'(c0_b), 32'd1);

      // Random traffic against the reference.
      for (int i = 0; i < 400; i++) begin
         step("rand", 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 2) != 0), rdy);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
